// File: rtl/int_layer2_mac_if.sv
// Bus between the layer-2 MAC engine, its weight BRAM and its requester.
//   start       : request a pass (sampled only while busy is low)
//   act_vec     : packed signed hidden activations, activation i at [A_BITS*i +: A_BITS]
//   weight_addr : row address to the weight BRAM
//   weight_data : registered BRAM read data, valid one cycle after weight_addr
//   busy        : pass in progress
//   done        : one-cycle pulse, acc_out valid
//   acc_out     : packed signed logits, logit j at [ACC_BITS*j +: ACC_BITS]
// slave is the MAC engine; master is the requester/BRAM side.
interface int_layer2_mac_if #(
    parameter int unsigned N_IN      = 32,
    parameter int unsigned N_OUT     = 10,
    parameter int unsigned W_BITS    = 16,
    parameter int unsigned A_BITS    = 16,
    parameter int unsigned ACC_BITS  = 40,
    parameter int unsigned ADDR_BITS = 6
);
    logic                      start;
    logic [N_IN*A_BITS-1:0]    act_vec;
    logic [ADDR_BITS-1:0]      weight_addr;
    logic [N_OUT*W_BITS-1:0]   weight_data;
    logic                      busy;
    logic                      done;
    logic [N_OUT*ACC_BITS-1:0] acc_out;

    modport slave (
        input  start, act_vec, weight_data,
        output weight_addr, busy, done, acc_out
    );

    modport master (
        output start, act_vec, weight_data,
        input  weight_addr, busy, done, acc_out
    );
endinterface

// File: rtl/int_layer2_mac.sv
// Layer-2 read sequencer and multiply-accumulate engine for the MNIST MLP.
// Walks the N_IN-row weight BRAM (one row of N_OUT packed signed weights per hidden
// neuron), multiplies each row by its captured hidden activation and accumulates
// N_OUT signed logits, then pulses done.
// Ports:
//   clk   : rising-edge clock, shared with the weight BRAM
//   rst_n : asynchronous active-low reset
//   bus   : int_layer2_mac_if slave (start/act_vec in, weight_addr/weight_data BRAM
//           port, busy/done/acc_out result)
module int_layer2_mac #(
    parameter int unsigned N_IN      = 32,
    parameter int unsigned N_OUT     = 10,
    parameter int unsigned W_BITS    = 16,
    parameter int unsigned A_BITS    = 16,
    parameter int unsigned ACC_BITS  = 40,
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    int_layer2_mac_if.slave bus
);
    localparam int unsigned IdxBits  = $clog2(N_IN);
    localparam int unsigned ProdBits = W_BITS + A_BITS;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  capture;

    // Read pipeline: v1_q/idx1_q mark which row the BRAM is returning this cycle.
    logic                  v1_q;
    logic [IdxBits-1:0]    idx1_q;

    logic signed [A_BITS-1:0]   act_q [N_IN];
    logic signed [ACC_BITS-1:0] acc_q [N_OUT];
    logic signed [ACC_BITS-1:0] acc_d [N_OUT];
    logic signed [ProdBits-1:0] prod  [N_OUT];
    logic signed [A_BITS-1:0]   act_sel;

    assign capture = (state_q == StIdle) && bus.start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                addr_d = '0;
                if (bus.start) begin
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (addr_q == ADDR_BITS'(N_IN - 1)) begin
                    addr_d  = '0;
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
            end
            StDrain: begin
                // Last row's accumulate lands on this edge.
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                addr_d  = '0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // Lane 0 is the most significant W_BITS of the row.
    always_comb begin
        act_sel = act_q[idx1_q];
        for (int j = 0; j < N_OUT; j++) begin
            prod[j] = ProdBits'(act_sel) *
                      ProdBits'($signed(bus.weight_data[N_OUT*W_BITS-1-W_BITS*j -: W_BITS]));
            acc_d[j] = acc_q[j];
            if (capture) begin
                acc_d[j] = '0;
            end else if (v1_q) begin
                acc_d[j] = acc_q[j] + ACC_BITS'(prod[j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            v1_q    <= 1'b0;
            idx1_q  <= '0;
            for (int i = 0; i < N_IN; i++) begin
                act_q[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            v1_q    <= (state_q == StFetch);
            idx1_q  <= addr_q[IdxBits-1:0];
            if (capture) begin
                for (int i = 0; i < N_IN; i++) begin
                    act_q[i] <= bus.act_vec[A_BITS*i +: A_BITS];
                end
            end
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign bus.weight_addr = addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    for (genvar j = 0; j < N_OUT; j++) begin : g_acc_out
        assign bus.acc_out[ACC_BITS*j +: ACC_BITS] = acc_q[j];
    end
endmodule

// File: tb/tb_int_layer2_mac.sv
module tb_int_layer2_mac;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int_layer2_mac_if bus ();

    int_layer2_mac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [159:0] mem [32];
    logic [15:0]  act [32];

    // Weight BRAM: registered read, one cycle latency.
    always @(posedge clk) bus.weight_data <= mem[bus.weight_addr[4:0]];

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: logit j = sum over rows of act[i] * lane j of row i.
    function automatic logic [39:0] ref_logit(input int j);
        longint s = 0;
        for (int i = 0; i < 32; i++) begin
            s += longint'($signed(act[i])) * longint'($signed(mem[i][159-16*j -: 16]));
        end
        return s[39:0];
    endfunction

    function automatic logic [511:0] pack_act();
        logic [511:0] v;
        for (int i = 0; i < 32; i++) v[16*i +: 16] = act[i];
        return v;
    endfunction

    task automatic fill_all(input logic [15:0] w, input logic [15:0] a);
        for (int i = 0; i < 32; i++) begin
            mem[i] = {10{w}};
            act[i] = a;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 10; j++) mem[i][16*j +: 16] = 16'($urandom);
            act[i] = 16'($urandom);
        end
    endtask

    function automatic logic [63:0] logit(input int j);
        return {24'b0, bus.acc_out[40*j +: 40]};
    endfunction

    // Called at a negedge; start is seen by the following posedge (E0).
    task automatic start_pass();
        bus.act_vec = pack_act();
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Sample k is the negedge after edge Ek. Optionally pulses start and scrambles
    // act_vec at sample inject_k to show both are ignored mid-pass.
    task automatic wait_done(input int inject_k, output int lat, output int busy_cnt,
                             output bit addr_ok);
        int k = 0;
        lat = -1;
        busy_cnt = 0;
        addr_ok = 1'b1;
        while (k <= 60) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (k < 32 && bus.weight_addr !== 6'(k)) addr_ok = 1'b0;
            if (k == inject_k) begin
                bus.start = 1'b1;
                for (int w = 0; w < 16; w++) bus.act_vec[32*w +: 32] = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_checked(input string name, input int inject_k);
        int  lat;
        int  busy_cnt;
        bit  addr_ok;
        start_pass();
        wait_done(inject_k, lat, busy_cnt, addr_ok);
        check({name, "_latency"}, 64'(lat), 64'd33);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, "_addr_seq"}, 64'(addr_ok), 64'd1);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("%s_logit%0d", name, j), logit(j), {24'b0, ref_logit(j)});
        end
    endtask

    initial begin
        int  found;
        int  seen;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.act_vec = '0;
        fill_all(16'h0000, 16'h0000);
        #23;
        check("rst_addr", 64'(bus.weight_addr), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_acc_zero", 64'(bus.acc_out == '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All ones.
        fill_all(16'h0001, 16'h0001);
        run_checked("ones", -1);
        check("ones_lit0", logit(0), 64'd32);
        @(negedge clk);
        check("ones_done_pulse", 64'(bus.done), 64'd0);

        // All -1 weights, activation i = i.
        fill_all(16'hFFFF, 16'h0000);
        for (int i = 0; i < 32; i++) act[i] = 16'(i);
        run_checked("neg", -1);
        check("neg_lit9", logit(9), 64'h00_0000_FFFF_FFFE10 & 64'hFF_FFFF_FFFF);
        @(negedge clk);

        // Lane ordering: lane 0 is the top 16 bits.
        fill_all(16'h0000, 16'h0000);
        mem[5][159:144] = 16'h0002;
        act[5]          = 16'd7;
        run_checked("lane0", -1);
        check("lane0_lit0", logit(0), 64'd14);
        check("lane0_lit1", logit(1), 64'd0);
        @(negedge clk);
        mem[5]        = '0;
        mem[5][15:0]  = 16'h0002;
        run_checked("lane9", -1);
        check("lane9_lit9", logit(9), 64'd14);
        check("lane9_lit0", logit(0), 64'd0);
        @(negedge clk);

        // Mid-pass start/act change ignored, then back-to-back start in the done cycle.
        fill_random();
        run_checked("midstart", 10);
        run_checked("b2b", -1);
        @(negedge clk);

        // Extremes: (-2^15)^2 * 32 = 2^35.
        fill_all(16'h8000, 16'h8000);
        run_checked("ext", -1);
        check("ext_lit4", logit(4), 64'd34359738368);
        @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_checked($sformatf("rand%0d", r), -1);
            @(negedge clk);
        end

        // Reset mid-pass.
        fill_all(16'h0001, 16'h0001);
        start_pass();
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.weight_addr == 6'd10) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_addr", 64'(bus.weight_addr), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_done", 64'(bus.done), 64'd0);
        check("rst_mid_acc_zero", 64'(bus.acc_out == '0), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("rst_mid_no_done", 64'(seen), 64'd0);
        run_checked("post_rst", -1);
        check("post_rst_lit0", logit(0), 64'd32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/int_layer2_mac.md
Name: int_layer2_mac

Overview:
- Read-side sequencer and multiply-accumulate engine for layer 2 of the MNIST MLP.
- Walks the 32-row layer-2 weight BRAM (160-bit rows = 10 packed signed 16-bit weights, one row per hidden neuron).
- Absorbs the BRAM's 1-cycle registered read latency and multiplies each row by the matching hidden activation.
- Accumulates 10 signed output logits and hands them to the argmax stage with a done pulse.

Parameters:
- N_IN, 32, hidden activations = weight BRAM rows.
- N_OUT, 10, output neurons = 16-bit lanes per row.
- W_BITS, 16, signed weight width.
- A_BITS, 16, signed activation width.
- ACC_BITS, 40, signed accumulator width per output.
- ADDR_BITS, 6, weight BRAM address width.

Ports:
- clk  in  1  rising-edge clock, shared with the weight BRAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a pass; sampled only when busy=0.
- act_vec  in  N_IN*A_BITS  hidden activations; activation i = act_vec[A_BITS*i +: A_BITS], signed.
- weight_addr  out  ADDR_BITS  row address to the weight BRAM.
- weight_data  in  N_OUT*W_BITS  BRAM read data, valid 1 cycle after weight_addr.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse; acc_out valid.
- acc_out  out  N_OUT*ACC_BITS  logit j = acc_out[ACC_BITS*j +: ACC_BITS], signed.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=IDLE.
  - weight_addr, busy, done, acc_out, internal valid/index pipeline and captured activations all 0.
- Lane mapping: output j uses weight_data[N_OUT*W_BITS-1-W_BITS*j -: W_BITS], so lane 0 is bits [159:144].
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - On start=1 at edge E0: capture act_vec into an internal register, clear all accumulators, weight_addr<=0, busy<=1, go to FETCH.
  - Otherwise weight_addr holds 0.
- FETCH:
  - weight_addr increments by 1 each edge, so it presents 0..31 on 32 consecutive cycles (E0..E31).
  - At E32, with weight_addr=31 presented, go to DRAIN and set weight_addr<=0.
- Read pipeline:
  - v1<=(state==FETCH); idx1<=weight_addr.
  - Rows arrive from the BRAM one cycle after their address is presented.
  - When v1=1: acc[j] <= acc[j] + sext(act[idx1] * lane_j(weight_data)) for all j in parallel.
  - Multiplies are full 32-bit signed products, sign-extended to ACC_BITS.
  - Accumulation occurs at E2..E33.
- DRAIN:
  - At E33 the row-31 accumulation completes; state<=IDLE, busy<=0, done<=1 for exactly one cycle.
  - Latency from start sample to done high is 33 edges.
- Arithmetic: worst case magnitude 32 * 2^30 = 2^35 fits in 40 bits, so no saturation or wrap handling is needed.
- acc_out:
  - Driven directly from the accumulators and valid from done onward.
  - Holds until the next accepted start clears it.
- start while busy=1 is ignored.
- start in the done cycle (busy=0) is accepted, giving back-to-back passes.
- act_vec changes after the start sample do not affect the pass in flight.
- Reset mid-pass aborts immediately: all outputs 0, no done pulse. The next start runs a complete, correct pass.

Test Plan:
- Bench BRAM model with all lanes 0x0001 and all activations 0x0001; start -> done 33 cycles later, every logit = 32.
- All lanes 0xFFFF (-1), activation i = i -> every logit = -496 (0xFFFFFFFE10 in 40 bits).
- Lane ordering: only row 5 bits [159:144]=0x0002, act5=7, all else 0 -> logit0=14, logits 1..9 = 0. Repeat with bits [15:0] -> logit9=14.
- Timing: weight_addr shows 0..31 on consecutive cycles after start; busy high for 33 cycles; done exactly one cycle; a start pulse mid-pass is ignored, and a start in the done cycle launches a second pass with identical results.
- Extremes: all weights 0x8000 and all activations 0x8000 -> every logit = 2^35 = 34359738368 with no wrap.
- Assert rst_n low when weight_addr=10 -> outputs 0 immediately, no done. Release reset, start -> the correct result from the first scenario.
